// File: rtl/mem_ctrl.sv
// Byte-serial memory arbiter/sequencer shared by instruction fetch and the MEM stage.
// Splits 1/2/4-byte little-endian accesses into single-byte RAM transfers and reassembles reads.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        owner;
  logic [1:0]        last;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wbuf;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rd_next;
  logic [2:0]        iss;
  logic [2:0]        cap;
  logic              pres_v;
  logic [1:0]        pres_i;
  logic              data_v;
  logic [1:0]        data_i;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic [1:0]        mem_last;
  logic              cap_hit;

  assign mem_last = (mem_len == 2'd2) ? 2'd3 : mem_len;

  // ram_din carries the byte whose address was presented one cycle earlier;
  // the tag lets the capture side ignore stale or repeated bytes after a pause.
  assign cap_hit = data_v && (data_i == cap[1:0]);

  always_comb begin
    rd_next = rbuf;
    rd_next[8*cap[1:0] +: 8] = ram_din;
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q & rdy & ~rst;
  assign if_done   = if_done_q & rdy & ~rst & ~flush;
  assign mem_done  = mem_done_q & rdy & ~rst;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_NONE;
      last        <= 2'd0;
      base        <= '0;
      wbuf        <= '0;
      rbuf        <= '0;
      iss         <= 3'd0;
      cap         <= 3'd0;
      pres_v      <= 1'b0;
      pres_i      <= 2'd0;
      data_v      <= 1'b0;
      data_i      <= 2'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      data_v <= pres_v;
      data_i <= pres_i;
      if (!rdy) begin
        // Frozen: keep presenting the oldest uncaptured byte so its data is
        // already on ram_din when rdy returns.
        if (state == S_READ) begin
          ram_a_q <= base + ADDR_W'(cap);
          pres_v  <= 1'b1;
          pres_i  <= cap[1:0];
          iss     <= cap + 3'd1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            pres_v     <= 1'b0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            if (mem_req) begin
              owner   <= OWN_MEM;
              base    <= mem_addr;
              last    <= mem_last;
              wbuf    <= mem_wdata;
              rbuf    <= '0;
              cap     <= 3'd0;
              iss     <= 3'd1;
              ram_a_q <= mem_addr;
              if (mem_we) begin
                state      <= S_WRITE;
                ram_dout_q <= mem_wdata[7:0];
                ram_wr_q   <= 1'b1;
              end else begin
                state  <= S_READ;
                pres_v <= 1'b1;
                pres_i <= 2'd0;
              end
            end else if (if_req && !flush) begin
              owner   <= OWN_IF;
              base    <= if_addr;
              last    <= 2'd3;
              rbuf    <= '0;
              cap     <= 3'd0;
              iss     <= 3'd1;
              ram_a_q <= if_addr;
              state   <= S_READ;
              pres_v  <= 1'b1;
              pres_i  <= 2'd0;
            end
          end

          S_READ: begin
            if (flush && owner == OWN_IF) begin
              state  <= S_IDLE;
              owner  <= OWN_NONE;
              pres_v <= 1'b0;
            end else begin
              if (cap_hit) begin
                rbuf <= rd_next;
                cap  <= cap + 3'd1;
                if (cap[1:0] == last) begin
                  state <= S_DONE;
                  if (owner == OWN_IF) begin
                    if_done_q <= 1'b1;
                    if_inst_q <= rd_next;
                  end else begin
                    mem_done_q  <= 1'b1;
                    mem_rdata_q <= rd_next;
                  end
                end
              end
              if (iss <= {1'b0, last}) begin
                ram_a_q <= base + ADDR_W'(iss);
                pres_v  <= 1'b1;
                pres_i  <= iss[1:0];
                iss     <= iss + 3'd1;
              end else begin
                pres_v <= 1'b0;
              end
            end
          end

          S_WRITE: begin
            if (iss <= {1'b0, last}) begin
              ram_a_q    <= base + ADDR_W'(iss);
              ram_dout_q <= wbuf[8*iss[1:0] +: 8];
              ram_wr_q   <= 1'b1;
              iss        <= iss + 3'd1;
            end else begin
              ram_wr_q   <= 1'b0;
              state      <= S_DONE;
              mem_done_q <= 1'b1;
            end
          end

          S_DONE: begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            pres_v     <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
